// File: rtl/dft_ctrl_pt_load.sv
// dft_ctrl_pt_load: serial-load DFT control-point block.
//
// A control word is shifted LSB first from the scan chain into a shadow
// register. One update cycle then copies it into the WIDTH-bit control
// register. While TE=1 the control register overrides the functional bus.
//
// Ports:
//   CP     clock (rising edge)
//   CDN    asynchronous active-low reset
//   TE     test enable: selects q_reg onto Z and permits loading
//   START  load request, sampled only in IDLE
//   SI     serial data in, LSB first
//   HOLD   stalls the update transfer while 1
//   D      functional values
//   Z      control-point outputs, Z[i] = TE ? q_reg[i] : D[i]
//   SO     serial out = shadow[0], chains to the next segment
//   BUSY   1 whenever the controller is not idle
//   DONE   registered one-cycle pulse after a completed update

// One control point: a shadow bit in the scan chain, a control bit that
// captures it on update, and the test-mode output mux.
module dft_ctrl_pt_load_cell (
  input  logic CP,
  input  logic CDN,
  input  logic shift_en,
  input  logic upd_en,
  input  logic te,
  input  logic sin,
  input  logic d,
  output logic shd,
  output logic q,
  output logic z
);

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      shd <= 1'b0;
      q   <= 1'b0;
    end else begin
      if (shift_en) shd <= sin;
      if (upd_en)   q   <= shd;
    end
  end

  assign z = te ? q : d;

endmodule

module dft_ctrl_pt_load #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             TE,
  input  logic             START,
  input  logic             SI,
  input  logic             HOLD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Z,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             shift_en, upd_en;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] q_reg;

  // State, counter and DONE registers.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      DONE    <= done_d;
    end
  end

  // Next state. Dropping TE mid-load aborts at the next edge without
  // shifting or updating; the shadow keeps whatever it has collected.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    upd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START && TE) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!TE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shift_en = 1'b1;
          // Counter parks at WIDTH-1 across UPDATE rather than wrapping.
          if (cnt_q == CNT_LAST) state_d = UPDATE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        if (!TE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!HOLD) begin
          upd_en  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control-point array; shadow shifts toward bit 0 with SI entering at the top.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cp
    logic sin;
    if (i == WIDTH - 1) begin : g_top
      assign sin = SI;
    end else begin : g_mid
      assign sin = shadow[i+1];
    end
    dft_ctrl_pt_load_cell u_cell (
      .CP       (CP),
      .CDN      (CDN),
      .shift_en (shift_en),
      .upd_en   (upd_en),
      .te       (TE),
      .sin      (sin),
      .d        (D[i]),
      .shd      (shadow[i]),
      .q        (q_reg[i]),
      .z        (Z[i])
    );
  end

  assign SO   = shadow[0];
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_dft_ctrl_pt_load.sv
// Scoreboard bench for dft_ctrl_pt_load (WIDTH=8). Each load pushes the word
// expected on Z into a queue; a monitor pops and compares whenever DONE is seen.
module tb_dft_ctrl_pt_load;

  logic       CP, CDN, TE, START, SI, HOLD;
  logic [7:0] D, Z;
  logic       SO, BUSY, DONE;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] q_model;
  logic [7:0] sh_model;

  dft_ctrl_pt_load #(.WIDTH(8), .CNT_W(4)) dut (
    .CP(CP), .CDN(CDN), .TE(TE), .START(START), .SI(SI), .HOLD(HOLD),
    .D(D), .Z(Z), .SO(SO), .BUSY(BUSY), .DONE(DONE)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DONE pulse must match a queued expected word on Z.
  always @(negedge CP) begin
    if (CDN && DONE === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: DONE=1 with no load pending at %0t", $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Z !== e) begin
          errors++;
          $display("FAIL done_z: got %0h expected %0h at %0t", Z, e, $time);
        end
      end
    end
  end

  // Full load; caller is 1 time unit after a rising edge. hold_n stall cycles at UPDATE.
  task automatic do_load(input logic [7:0] val, input int hold_n);
    int busy_n;
    busy_n = 0;
    TE = 1'b1; START = 1'b1; HOLD = 1'b0;
    @(posedge CP); #1;            // edge 0
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SI = val[i];
      if (i == 7 && hold_n > 0) HOLD = 1'b1;
      @(negedge CP); busy_n += BUSY;
      @(posedge CP); #1;
      sh_model = {val[i], sh_model[7:1]};
      chk("so_shift", SO, sh_model[0]);
    end
    for (int h = 0; h < hold_n; h++) begin
      @(negedge CP); busy_n += BUSY;
      chk("stall_done", DONE, 1'b0);
      chk("stall_z", Z, q_model);
      @(posedge CP); #1;
    end
    HOLD = 1'b0;
    exp_q.push_back(val);
    @(negedge CP); busy_n += BUSY;
    @(posedge CP); #1;            // update edge
    q_model = val;
    chk("busy_cycles", busy_n, 9 + hold_n);
    @(negedge CP);
    chk("busy_after", BUSY, 1'b0);
    chk("done_high", DONE, 1'b1);
    @(posedge CP); #1;
    @(negedge CP);
    chk("done_width", DONE, 1'b0);
    @(posedge CP); #1;
  endtask

  initial begin
    CDN = 1'b0; TE = 1'b0; START = 1'b0; SI = 1'b0; HOLD = 1'b0; D = 8'h55;
    q_model = 8'h00; sh_model = 8'h00;
    #12;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_so", SO, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_z_func", Z, 8'h55);
    TE = 1'b1; #1;
    chk("rst_z_test", Z, 8'h00);
    @(posedge CP); #1;
    CDN = 1'b1;
    @(posedge CP); #1;

    // 1: basic load
    do_load(8'hA5, 0);
    chk("s1_z", Z, 8'hA5);

    // 2: mode mux
    TE = 1'b0; D = 8'h3C; #1;
    chk("s2_func", Z, 8'h3C);
    TE = 1'b1; #1;
    chk("s2_test", Z, 8'hA5);
    @(posedge CP); #1;

    // 3: HOLD stall
    do_load(8'h0F, 3);
    chk("s3_z", Z, 8'h0F);

    // 4: abort after 4 shifts of 1s
    TE = 1'b1; START = 1'b1;
    @(posedge CP); #1;
    START = 1'b0; SI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CP); #1;
      sh_model = {1'b1, sh_model[7:1]};
    end
    TE = 1'b0;
    @(posedge CP); #1;
    @(negedge CP);
    chk("s4_busy", BUSY, 1'b0);
    chk("s4_so", SO, sh_model[0]);
    @(posedge CP); #1;
    TE = 1'b1; #1;
    chk("s4_q_kept", Z, 8'h0F);
    repeat (2) @(posedge CP);
    #1;
    do_load(8'h81, 0);
    chk("s4_reload", Z, 8'h81);

    // 5: SO chaining, shadow 0x81 drains as 0,0,0,0,0,0,1,0
    chk("s5_shadow_pre", sh_model, 8'h81);
    do_load(8'h00, 0);
    chk("s5_z", Z, 8'h00);

    // 6: asynchronous reset mid-shift (load 0x5A first so q_reg is nonzero)
    do_load(8'h5A, 0);
    START = 1'b1;
    @(posedge CP); #1;
    START = 1'b0; SI = 1'b1;
    repeat (3) @(posedge CP);
    #1;
    CDN = 1'b0; #1;
    q_model = 8'h00; sh_model = 8'h00;
    chk("s6_busy", BUSY, 1'b0);
    chk("s6_so", SO, 1'b0);
    chk("s6_z", Z, 8'h00);
    chk("s6_done", DONE, 1'b0);
    START = 1'b1;
    repeat (2) @(posedge CP);
    #1;
    chk("s6_start_ign", BUSY, 1'b0);
    START = 1'b0;
    CDN = 1'b1;
    @(posedge CP); #1;
    chk("s6_idle", BUSY, 1'b0);
    do_load(8'h5A, 0);
    chk("s6_z_final", Z, 8'h5A);

    repeat (3) @(posedge CP);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
